ipuf_seq_ctrl: RTL and testbench

//  Sequencer for the (1,K)-interpose PUF: takes an N1-bit challenge, runs the upper XOR APUF,

---
 rtl/ipuf_pkg.sv | 43 ++++
 rtl/ipuf_cnt.sv | 44 ++++
 rtl/ipuf_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ipuf_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ipuf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ipuf_pkg
// Purpose  : Shared types and helpers for the (1,K)-interpose PUF sequencer:
//            FSM state encoding, timer width and the challenge interpose
//            function.
// Revision : 1.0 - initial release
// ============================================================================
package ipuf_pkg;

  // Width of the shared settle/timeout counter.
  localparam int TIMER_W = 16;

  // Widest upper-PUF challenge the interpose helper supports.
  localparam int MAX_N1 = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SET_T  = 3'd1,
    ST_TRG_T  = 3'd2,
    ST_WAIT_T = 3'd3,
    ST_SET_B  = 3'd4,
    ST_TRG_B  = 3'd5,
    ST_WAIT_B = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  // Build the lower-PUF challenge: bits [pos:0] pass straight through, the
  // interposed bit lands at pos+1 and the remaining upper bits move up one.
  function automatic logic [MAX_N1:0] interpose(input logic [MAX_N1-1:0] chal,
                                                input logic              ins,
                                                input logic [6:0]        pos);
    logic [MAX_N1:0] ext;
    logic [MAX_N1:0] m_lo;
    logic [MAX_N1:0] m_hi;
    ext  = {1'b0, chal};
    m_lo = ~({(MAX_N1+1){1'b1}} << (pos + 7'd1));
    m_hi = {(MAX_N1+1){1'b1}} << (pos + 7'd2);
    return (ext & m_lo) | ((ext << 1) & m_hi) | ({(MAX_N1+1){ins}} & ~(m_lo | m_hi));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ipuf_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ipuf_cnt
// Purpose  : Clear/enable saturating up-counter with an equality compare
//            output. Shared by the settle and ready-timeout phases.
// Revision : 1.0 - initial release
// ============================================================================
module ipuf_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] cmp,
  output logic         eq
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign eq = (cnt_q == cmp);

endmodule
`default_nettype wire

// File: rtl/ipuf_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ipuf_seq_ctrl
// Purpose  : Sequencer for the (1,K)-interpose PUF. Runs the upper XOR APUF,
//            interposes its bit into the lower challenge, runs the lower XOR
//            APUF and hands the final response bit back to the host.
// Revision : 1.0 - initial release
// ============================================================================
module ipuf_seq_ctrl
  import ipuf_pkg::*;
#(
  parameter int N1      = 16,
  parameter int POS     = N1 / 2,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N1-1:0] chal_in,
  input  logic          chal_valid,
  output logic          chal_ready,
  output logic          resp_bit,
  output logic          resp_err,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [N1:0]   puf_c,
  output logic          tig_t,
  output logic          tig_b,
  input  logic          rdy_t,
  input  logic          rdy_b,
  input  logic          bit_t,
  input  logic          bit_b
);

  state_e        state_q, state_d;
  logic [N1-1:0] chal_q, chal_d;
  logic [N1:0]   puf_c_q, puf_c_d;
  logic          chal_ready_q, chal_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_bit_q, resp_bit_d;
  logic          resp_err_q, resp_err_d;
  logic          tig_t_q, tig_t_d;
  logic          tig_b_q, tig_b_d;

  logic               cnt_clr;
  logic               cnt_en;
  logic               cnt_eq;
  logic [TIMER_W-1:0] cnt_cmp;

  // One counter serves both phases; the compare target switches between
  // the settle length and the ready timeout depending on the state.
  ipuf_cnt #(.W(TIMER_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cmp (cnt_cmp),
    .eq  (cnt_eq)
  );

  // Next-state and next-output logic; triggers default low so each pulse
  // lasts only the TRG cycle it was launched into.
  always_comb begin
    state_d      = state_q;
    chal_d       = chal_q;
    puf_c_d      = puf_c_q;
    chal_ready_d = chal_ready_q;
    resp_valid_d = resp_valid_q;
    resp_bit_d   = resp_bit_q;
    resp_err_d   = resp_err_q;
    tig_t_d      = 1'b0;
    tig_b_d      = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    cnt_cmp      = TIMER_W'(SETTLE - 1);
    case (state_q)
      ST_IDLE: begin
        cnt_clr      = 1'b1;
        chal_ready_d = 1'b1;
        if (chal_valid && chal_ready_q) begin
          chal_d       = chal_in;
          puf_c_d      = (N1+1)'(interpose(MAX_N1'(chal_in), 1'b0, 7'(POS)));
          chal_ready_d = 1'b0;
          state_d      = ST_SET_T;
        end
      end
      ST_SET_T: begin
        if (cnt_eq) begin
          tig_t_d = 1'b1;
          state_d = ST_TRG_T;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_TRG_T: begin
        cnt_clr = 1'b1;
        state_d = ST_WAIT_T;
      end
      ST_WAIT_T: begin
        cnt_cmp = TIMER_W'(TIMEOUT);
        if (rdy_t) begin
          puf_c_d = (N1+1)'(interpose(MAX_N1'(chal_q), bit_t, 7'(POS)));
          cnt_clr = 1'b1;
          state_d = ST_SET_B;
        end else if (cnt_eq) begin
          resp_err_d   = 1'b1;
          resp_bit_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_SET_B: begin
        if (cnt_eq) begin
          tig_b_d = 1'b1;
          state_d = ST_TRG_B;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_TRG_B: begin
        cnt_clr = 1'b1;
        state_d = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        cnt_cmp = TIMER_W'(TIMEOUT);
        if (rdy_b) begin
          resp_bit_d   = bit_b;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = ST_DONE;
        end else if (cnt_eq) begin
          resp_err_d   = 1'b1;
          resp_bit_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          chal_ready_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset drops any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      chal_q       <= '0;
      puf_c_q      <= '0;
      chal_ready_q <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_bit_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      tig_t_q      <= 1'b0;
      tig_b_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      chal_q       <= chal_d;
      puf_c_q      <= puf_c_d;
      chal_ready_q <= chal_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_bit_q   <= resp_bit_d;
      resp_err_q   <= resp_err_d;
      tig_t_q      <= tig_t_d;
      tig_b_q      <= tig_b_d;
    end
  end

  assign chal_ready = chal_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_bit   = resp_bit_q;
  assign resp_err   = resp_err_q;
  assign puf_c      = puf_c_q;
  assign tig_t      = tig_t_q;
  assign tig_b      = tig_b_q;

endmodule
`default_nettype wire

// File: tb/tb_ipuf_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ipuf_seq_ctrl
// Purpose  : Self-checking bench for ipuf_seq_ctrl. A transaction-level model
//            predicts trigger cycles, puf_c contents, response timing and
//            value from the sequencing rules; the bench also plays the PUF.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ipuf_seq_ctrl;

  localparam int N1    = 16;
  localparam int POS   = 8;
  localparam int S     = 4;
  localparam int TO    = 10;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic [N1-1:0] chal_in;
  logic          chal_valid;
  logic          chal_ready;
  logic          resp_bit;
  logic          resp_err;
  logic          resp_valid;
  logic          resp_ready;
  logic [N1:0]   puf_c;
  logic          tig_t;
  logic          tig_b;
  logic          rdy_t;
  logic          rdy_b;
  logic          bit_t;
  logic          bit_b;

  int            total = 0;
  int            bad   = 0;
  logic [N1:0]   last_puf;
  int            meas_lat;
  logic [N1:0]   meas_puf_cap;

  ipuf_seq_ctrl #(.N1(N1), .POS(POS), .SETTLE(S), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .chal_in    (chal_in),
    .chal_valid (chal_valid),
    .chal_ready (chal_ready),
    .resp_bit   (resp_bit),
    .resp_err   (resp_err),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .puf_c      (puf_c),
    .tig_t      (tig_t),
    .tig_b      (tig_b),
    .rdy_t      (rdy_t),
    .rdy_b      (rdy_b),
    .bit_t      (bit_t),
    .bit_b      (bit_b)
  );

  always #5 clk = ~clk;

  // Walk the lower challenge bit by bit, dropping b in at POS+1.
  function automatic logic [N1:0] model_ip(input logic [N1-1:0] c, input logic b);
    logic [N1:0] r;
    int          j;
    j = 0;
    for (int i = 0; i <= N1; i++) begin
      if (i == POS + 1) begin
        r[i] = b;
      end else begin
        r[i] = c[j];
        j++;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_idle();
    chk("idle_chal_ready", 32'(chal_ready), 32'd1);
    chk("idle_resp_valid", 32'(resp_valid), 32'd0);
    chk("idle_tig_t", 32'(tig_t), 32'd0);
    chk("idle_tig_b", 32'(tig_b), 32'd0);
    chk("idle_puf_c", 32'(puf_c), 32'(last_puf));
    chal_valid = 1'b0;
    resp_ready = 1'b0;
    rdy_t      = 1'b0;
    rdy_b      = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_idle();
      chal_valid = 1'(($urandom_range(0, 1)) & (i + 1 < n ? 1 : 0));
      chal_valid = 1'b0;
    end
  endtask

  // One challenge/response exchange. Cycle k is the cycle after the k-th
  // rising edge counted from the accepting edge (k = 0).
  task automatic run_txn(input logic [N1-1:0] chal, input int wt, input int wb,
                         input logic bt, input logic bb, input int ackd,
                         input int rst_at);
    int          tb_k, tv, wt_end, wb_end;
    bit          up_ok, lo_ok, aborted;
    logic        exp_bit, exp_err;
    logic [N1:0] p0, p1, exp_puf;
    up_ok  = (wt <= TO);
    lo_ok  = (wb <= TO);
    p0     = model_ip(chal, 1'b0);
    p1     = model_ip(chal, bt);
    tb_k   = 2 * S + 2 + wt;
    wt_end = S + 1 + (up_ok ? wt : TO);
    wb_end = tb_k + 1 + (lo_ok ? wb : TO);
    if (!up_ok) begin
      tv = S + 1 + TO + 1; exp_err = 1'b1; exp_bit = 1'b0;
    end else if (lo_ok) begin
      tv = tb_k + 1 + wb + 1; exp_err = 1'b0; exp_bit = bb;
    end else begin
      tv = tb_k + 1 + TO + 1; exp_err = 1'b1; exp_bit = 1'b0;
    end
    exp_puf  = p0;
    aborted  = 1'b0;
    meas_lat = -1;
    @(negedge clk);
    check_idle();
    chal_in    = chal;
    chal_valid = 1'b1;
    for (int k = 0; k <= tv + ackd; k++) begin
      @(negedge clk);
      exp_puf = (up_ok && k >= S + 2 + wt) ? p1 : p0;
      chk("tig_t", 32'(tig_t), 32'(k == S));
      chk("tig_b", 32'(tig_b), 32'(up_ok && k == tb_k));
      chk("puf_c", 32'(puf_c), 32'(exp_puf));
      chk("chal_ready_busy", 32'(chal_ready), 32'd0);
      chk("resp_valid", 32'(resp_valid), 32'(k >= tv));
      if (k >= tv) begin
        chk("resp_bit", 32'(resp_bit), 32'(exp_bit));
        chk("resp_err", 32'(resp_err), 32'(exp_err));
      end
      if (resp_valid && meas_lat < 0) meas_lat = k;
      if (up_ok && k == S + 2 + wt) meas_puf_cap = puf_c;
      // Busy-time challenge noise must be ignored.
      chal_valid = 1'($urandom_range(0, 3) == 0);
      chal_in    = 16'($urandom);
      // Upper PUF: silent through its wait window except the ready cycle.
      if (k >= S + 1 && k <= wt_end) rdy_t = 1'(up_ok && k == S + 1 + wt);
      else                           rdy_t = 1'($urandom_range(0, 1));
      bit_t = (up_ok && k == S + 1 + wt) ? bt : 1'($urandom_range(0, 1));
      if (up_ok && k >= tb_k + 1 && k <= wb_end) rdy_b = 1'(lo_ok && k == tb_k + 1 + wb);
      else                                       rdy_b = 1'($urandom_range(0, 1));
      bit_b = (up_ok && lo_ok && k == tb_k + 1 + wb) ? bb : 1'($urandom_range(0, 1));
      resp_ready = (k < tv) ? 1'($urandom_range(0, 1)) : 1'(k == tv + ackd);
      if (k == rst_at) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_chal_ready", 32'(chal_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_bit", 32'(resp_bit), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_tig_t", 32'(tig_t), 32'd0);
        chk("rst_tig_b", 32'(tig_b), 32'd0);
        chk("rst_puf_c", 32'(puf_c), 32'd0);
        last_puf = '0;
        aborted  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        break;
      end
    end
    if (!aborted) last_puf = exp_puf;
  endtask

  initial begin
    rst        = 1'b1;
    chal_in    = '0;
    chal_valid = 1'b0;
    resp_ready = 1'b0;
    rdy_t      = 1'b0;
    rdy_b      = 1'b0;
    bit_t      = 1'b0;
    bit_b      = 1'b0;
    last_puf   = '0;
    repeat (2) @(negedge clk);
    chk("reset_chal_ready", 32'(chal_ready), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_bit", 32'(resp_bit), 32'd0);
    chk("reset_resp_err", 32'(resp_err), 32'd0);
    chk("reset_tig_t", 32'(tig_t), 32'd0);
    chk("reset_tig_b", 32'(tig_b), 32'd0);
    chk("reset_puf_c", 32'(puf_c), 32'd0);
    rst = 1'b0;
    idle_cycles(2);

    // Reference exchange with hand-computed latency and interposed challenge.
    run_txn(16'hA5C3, 3, 5, 1'b1, 1'b0, 0, -1);
    chk("lit_latency", 32'(meas_lat), 32'd20);
    chk("lit_puf_cap", 32'(meas_puf_cap), 32'h14BC3);

    // Upper PUF never ready: abort after 4 + 1 + 11 cycles.
    run_txn(16'h0F0F, NEVER, 0, 1'b1, 1'b1, 1, -1);
    chk("lit_timeout_latency", 32'(meas_lat), 32'd16);

    // Host stalls the response for 50 cycles.
    run_txn(16'h1234, 1, 2, 1'b0, 1'b1, 50, -1);

    // Ready arriving in the timeout cycle still wins.
    run_txn(16'hBEEF, 0, TO, 1'b1, 1'b1, 0, -1);
    run_txn(16'h7001, TO, TO, 1'b0, 1'b1, 2, -1);

    // Lower PUF never ready.
    run_txn(16'hFFFF, 2, NEVER, 1'b1, 1'b1, 2, -1);

    // Reset while waiting on the lower PUF, then a clean run.
    run_txn(16'hCAFE, 2, 8, 1'b1, 1'b1, 0, 2 * S + 2 + 2 + 3);
    idle_cycles(15);
    run_txn(16'hCAFE, 2, 8, 1'b1, 1'b1, 0, -1);
    chk("lit_after_rst_latency", 32'(meas_lat), 32'd22);

    for (int n = 0; n < 30; n++) begin
      run_txn(16'($urandom), $urandom_range(0, TO + 2), $urandom_range(0, TO + 2),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), -1);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
